// File: rtl/button_pkg.sv
// Shared encodings for the front-panel button event decoder.
// Event kinds as presented on act_kind, plus the click FSM state type.
package button_pkg;

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_SINGLE = 2'b01;
  localparam logic [1:0] KIND_DOUBLE = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } click_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser plus stable-sample debouncer; level/rise follow raw by 2+DEBOUNCE_CYCLES cycles.
// No backpressure: rise is a one-cycle pulse coincident with level going high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic clear_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample agreeing with the current level restarts the run.
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Debounced buttons -> single/double click events; event registered 1 cycle after the deciding press/expiry.
// valid/ack output register: an emit while a held event is not acked is dropped and flagged on overrun.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int                 NUM_BTN         = 5,
  parameter int                 IDX_W           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter int                 DBL_WINDOW      = 32,
  parameter logic [NUM_BTN-1:0] DBL_MASK        = NUM_BTN'(1)
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               dbl_en,
  input  logic               act_ack,
  output logic               act_valid,
  output logic [IDX_W-1:0]   act_btn,
  output logic [1:0]         act_kind,
  output logic               overrun
);

  localparam int CNT_W = $clog2(DBL_WINDOW + 1);

  logic [NUM_BTN-1:0] db_level;
  logic [NUM_BTN-1:0] db_rise;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] others;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;

  click_state_t       state, state_d;
  logic [IDX_W-1:0]   lat, lat_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               emit;
  logic [IDX_W-1:0]   emit_btn;
  logic [1:0]         emit_kind;
  logic               drop;
  logic               load;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .clear_n (clear_n),
      .raw     (btn[i]),
      .level   (db_level[i]),
      .rise    (db_rise[i])
    );
  end

  assign press = db_rise & db_level;

  // Lowest index wins; every other simultaneous press is reported as dropped.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    others = press;
    if (win_vld) others[win_idx] = 1'b0;
  end

  always_comb begin
    state_d   = state;
    lat_d     = lat;
    cnt_d     = cnt;
    emit      = 1'b0;
    emit_btn  = lat;
    emit_kind = KIND_SINGLE;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          drop = |others;
          if (dbl_en && DBL_MASK[win_idx]) begin
            state_d = ST_ARMED;
            lat_d   = win_idx;
            cnt_d   = CNT_W'(DBL_WINDOW);
          end else begin
            emit     = 1'b1;
            emit_btn = win_idx;
          end
        end
      end
      ST_ARMED: begin
        cnt_d = cnt - CNT_W'(1);
        if (dbl_en && press[lat]) begin
          emit      = 1'b1;
          emit_kind = KIND_DOUBLE;
          drop      = |(press & ~(NUM_BTN'(1) << lat));
          state_d   = ST_IDLE;
        // Window closes on the cycle the counter steps to zero.
        end else if (win_vld || !dbl_en || cnt == CNT_W'(1)) begin
          emit    = 1'b1;
          drop    = win_vld;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load = emit && (!act_valid || act_ack);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
      lat   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      lat   <= lat_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      act_valid <= 1'b0;
      act_btn   <= '0;
      act_kind  <= KIND_NONE;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop | (emit & ~load);
      if (load) begin
        act_valid <= 1'b1;
        act_btn   <= emit_btn;
        act_kind  <= emit_kind;
      end else if (act_valid && act_ack) begin
        act_valid <= 1'b0;
        act_btn   <= '0;
        act_kind  <= KIND_NONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: debounce, click classification, priority, handshake, reset.
module tb_button_event_decoder;
  import button_pkg::*;

  logic       clk     = 1'b0;
  logic       clear_n = 1'b0;
  logic       dbl_en  = 1'b0;
  logic       act_ack = 1'b1;
  logic [4:0] btn     = '0;
  logic       act_valid;
  logic [2:0] act_btn;
  logic [1:0] act_kind;
  logic       overrun;

  int checks  = 0;
  int errors  = 0;
  int ev_cnt  = 0;
  int ovr_cnt = 0;
  int ev_base;
  int ovr_base;

  button_event_decoder #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (4),
    .DBL_WINDOW      (20),
    .DBL_MASK        (5'b00001)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .btn       (btn),
    .dbl_en    (dbl_en),
    .act_ack   (act_ack),
    .act_valid (act_valid),
    .act_btn   (act_btn),
    .act_kind  (act_kind),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Consumed events and overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (clear_n) begin
      if (act_valid && act_ack) ev_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input int b, input int k);
    check({tag, "_valid"}, int'(act_valid), 1);
    check({tag, "_btn"},   int'(act_btn),   b);
    check({tag, "_kind"},  int'(act_kind),  k);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_valid",   int'(act_valid), 0);
    check("rst_btn",     int'(act_btn),   0);
    check("rst_kind",    int'(act_kind),  0);
    check("rst_overrun", int'(overrun),   0);
    #2 clear_n = 1'b1;
    tick(3);

    // Bounce rejection on button 2
    ev_base = ev_cnt;
    for (int i = 0; i < 5; i++) begin
      btn[2] = 1'b1; tick(2);
      btn[2] = 1'b0; tick(2);
    end
    btn[2] = 1'b1;
    tick(6);
    check("bounce_early", int'(act_valid), 0);
    tick(1);
    expect_evt("bounce", 2, 1);
    tick(10);
    check("bounce_count", ev_cnt - ev_base, 1);
    btn = '0;
    tick(12);
    check("release_no_evt", ev_cnt - ev_base, 1);

    // Double-capable button with double-click disabled
    btn[0] = 1'b1;
    tick(6);
    check("nodbl_early", int'(act_valid), 0);
    tick(1);
    expect_evt("nodbl", 0, 1);
    btn = '0;
    tick(12);

    // Window expiry, button held across the window
    dbl_en = 1'b1;
    ev_base = ev_cnt;
    btn[0] = 1'b1;
    tick(26);
    check("expiry_early", int'(act_valid), 0);
    tick(1);
    expect_evt("expiry", 0, 1);
    tick(30);
    check("held_one_evt", ev_cnt - ev_base, 1);
    btn = '0;
    tick(12);

    // Double click: second debounced edge 10 cycles after the first
    ev_base = ev_cnt;
    btn[0] = 1'b1; tick(4);
    btn[0] = 1'b0; tick(6);
    btn[0] = 1'b1;
    tick(6);
    check("dbl_early", int'(act_valid), 0);
    tick(1);
    expect_evt("dbl", 0, 2);
    btn = '0;
    tick(30);
    check("dbl_no_single", ev_cnt - ev_base, 1);

    // dbl_en falling while armed
    btn[0] = 1'b1;
    tick(10);
    check("fall_armed", int'(act_valid), 0);
    dbl_en = 1'b0;
    tick(1);
    expect_evt("fall", 0, 1);
    btn = '0;
    tick(12);

    // Simultaneous presses on 3 and 1
    ovr_base = ovr_cnt;
    btn[3] = 1'b1;
    btn[1] = 1'b1;
    tick(7);
    expect_evt("prio", 1, 1);
    check("prio_overrun", int'(overrun), 1);
    tick(3);
    check("prio_ovr_count", ovr_cnt - ovr_base, 1);
    btn = '0;
    tick(12);

    // Armed on 0, then press 4
    dbl_en = 1'b1;
    ev_base = ev_cnt;
    ovr_base = ovr_cnt;
    btn[0] = 1'b1; tick(5);
    btn[4] = 1'b1; tick(6);
    check("intr_early", int'(act_valid), 0);
    tick(1);
    expect_evt("intr", 0, 1);
    check("intr_overrun", int'(overrun), 1);
    tick(30);
    check("intr_ev_count", ev_cnt - ev_base, 1);
    check("intr_ovr_count", ovr_cnt - ovr_base, 1);
    btn = '0;
    tick(12);

    // Handshake: held event, dropped second event, back-to-back reload
    dbl_en = 1'b0;
    act_ack = 1'b0;
    ev_base = ev_cnt;
    ovr_base = ovr_cnt;
    btn[2] = 1'b1; tick(3);
    btn[3] = 1'b1; tick(4);
    expect_evt("hs_first", 2, 1);
    tick(3);
    check("hs_drop_overrun", int'(overrun), 1);
    check("hs_hold_btn", int'(act_btn), 2);
    tick(5);
    expect_evt("hs_stable", 2, 1);
    check("hs_ovr_count", ovr_cnt - ovr_base, 1);
    btn[4] = 1'b1;
    tick(6);
    expect_evt("hs_pre_b2b", 2, 1);
    act_ack = 1'b1;
    tick(1);
    expect_evt("hs_b2b", 4, 1);
    check("hs_b2b_overrun", int'(overrun), 0);
    tick(1);
    check("hs_clear_valid", int'(act_valid), 0);
    check("hs_clear_kind", int'(act_kind), 0);
    check("hs_consumed", ev_cnt - ev_base, 2);
    btn = '0;
    tick(12);

    // Async reset mid-ARMED with an event pending
    dbl_en = 1'b1;
    act_ack = 1'b0;
    btn[2] = 1'b1; tick(2);
    btn[0] = 1'b1; tick(10);
    expect_evt("pre_rst", 2, 1);
    #2 clear_n = 1'b0;
    #1;
    check("arst_valid", int'(act_valid), 0);
    check("arst_btn",   int'(act_btn),   0);
    check("arst_kind",  int'(act_kind),  0);
    btn = '0;
    tick(2);
    #2 clear_n = 1'b1;
    act_ack = 1'b1;
    ev_base = ev_cnt;
    tick(40);
    check("post_rst_events", ev_cnt - ev_base, 0);
    check("post_rst_valid", int'(act_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Parametrised front-panel input decoder: synchronises and debounces `NUM_BTN` raw push-buttons, detects press edges, classifies them as single or double clicks per button, and presents one event at a time on a valid/ack handshake. It sits between the board buttons and the game controller, and supersedes the fixed five-button click decoder. The controller consumes events with `act_ack`.

## Interface
- `NUM_BTN`, 5: number of buttons; index 0 has highest priority.
- `IDX_W`, `$clog2(NUM_BTN)` (min 1): width of `act_btn`.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples needed to accept a new level (≥2).
- `DBL_WINDOW`, 32: cycles after a first press during which a second press counts as a double (≥2).
- `DBL_MASK`, `NUM_BTN'b1`: bit i set means button i is double-click capable.
- `clk`  in  1  clock; all flops are rising-edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `btn`  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- `dbl_en`  in  1  global double-click enable; 0 makes every press single.
- `act_ack`  in  1  consumer accepts the presented event.
- `act_valid`  out  1  event pending.
- `act_btn`  out  IDX_W  index of the event's button.
- `act_kind`  out  2  2'b01 single, 2'b10 double; 2'b00 when not valid.
- `overrun`  out  1  one-cycle pulse: an event was dropped.

## Operation
- Per button: 2-flop synchroniser, then a debouncer. The debounced level `db[i]` changes only after `DEBOUNCE_CYCLES` consecutive samples differ from it. The counter resets on any bounce. A press is a `db[i]` 0→1 edge. Releases generate no event.
- Same-cycle presses: the lowest index wins. The others are dropped and pulse `overrun`.
- Click FSM states:
  - IDLE:
    - Press on button b with `dbl_en && DBL_MASK[b]`: latch b, load the window counter with `DBL_WINDOW`, go to ARMED.
    - Any other press: emit single(b).
  - ARMED:
    - Counter decrements each cycle.
    - Press of the latched b: emit double(b), go to IDLE.
    - Press of a different button c: emit single(b) and drop c (`overrun`), go to IDLE.
    - Counter reaches 0 with no press: emit single(b), go to IDLE.
    - `dbl_en` falling while ARMED: emit single(b) immediately.
- Emit means loading the output register. A load happens only when `!act_valid || act_ack`. Otherwise the event is dropped and `overrun` pulses the following cycle.
- Handshake:
  - `act_valid/act_btn/act_kind` stay stable until a cycle with `act_valid && act_ack`.
  - After that cycle, `act_valid` deasserts, unless a new emit in the same cycle reloads it (back-to-back is allowed).
  - `act_ack` while `!act_valid` is ignored.
- Reset mid-operation: FSM returns to IDLE, the armed click is discarded, debouncers clear to 0, and any pending event is lost.

## Timing
- Reset values: `act_valid`=0, `act_btn`=0, `act_kind`=2'b00, `overrun`=0. Debounced levels, counters and synchroniser flops are all 0.
- Raw press to debounced edge: 2 (sync) + `DEBOUNCE_CYCLES` cycles, given a clean input.
- Non-double-capable press: `act_valid` rises 1 cycle after the debounced edge.
- Single on a double-capable button: `act_valid` rises `DBL_WINDOW`+1 cycles after the debounced edge.
- Double: `act_valid` rises 1 cycle after the second debounced edge.
- A button held across the window produces exactly one event.
- A button held down never re-arms until released and debounced low.

## Structure
- Shared package `button_pkg`:
  - kind constants `KIND_NONE=2'b00`, `KIND_SINGLE=2'b01`, `KIND_DOUBLE=2'b10`;
  - FSM state encodings `ST_IDLE`, `ST_ARMED`.
- Sub-module `btn_debounce`, one per button via generate. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `clear_n`, `raw`, `level`, `rise`. It contains the synchroniser and the counter.
- The top holds the priority encoder, click FSM, window counter and output register.

## Test plan
Common parameters: `NUM_BTN`=5, `DEBOUNCE_CYCLES`=4, `DBL_WINDOW`=20, `DBL_MASK`=5'b00001.
- **Bounce rejection:** `btn[2]` toggles every 2 cycles for 20 cycles, then stays high. Required: exactly one single(2), with `act_valid` rising 7 cycles after the final rising edge.
- **Double:** with `dbl_en`=1, press `btn[0]`, release, press again so that the second debounced edge lands 10 cycles after the first. Required: one event, kind 2'b10, btn 0, and no single.
- **Window expiry:** one press of `btn[0]` with `dbl_en`=1. Required: single(0) asserted 21 cycles after the debounced edge. With `dbl_en`=0, single(0) is asserted after 1 cycle.
- **Priority and interrupt:**
  - `btn[3]` and `btn[1]` rise together. Required: single(1) and an `overrun` pulse.
  - In ARMED on 0, press 4. Required: single(0) and `overrun`.
- **Handshake:** hold `act_ack`=0 and generate two events. Required: the first is held stable, the second is dropped with `overrun`. Ack in the same cycle as a new emit loads the new event with no gap.
- **Async reset:** assert `clear_n`=0 mid-ARMED, between clock edges. Required: outputs are 0 immediately, and no event appears after release.
